fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 SHALL have parameter HALT_INSTR, default 32'h00000073, encoding treated as program halt.
REQ-003 SHALL have parameter NOP_INSTR, default 32'h00000013, bubble encoding (addi x0,x0,0).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 stall  input  1  hazard-unit hold request for PC and IF/ID register.
REQ-007 redirect_valid  input  1  taken branch/jump from EX; flush and retarget.
REQ-008 redirect_pc  input  32  branch/jump target address.
REQ-009 imem_addr  output  32  fetch address to instruction memory (word index = addr[9:2]).
REQ-010 imem_instr  input  32  combinational instruction returned for imem_addr.
REQ-011 if_id_pc  output  32  PC of instruction held in IF/ID.
REQ-012 if_id_pc4  output  32  if_id_pc + 4, modulo 2^32.
REQ-013 if_id_instr  output  32  instruction held in IF/ID.
REQ-014 if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-015 halted  output  1  halt instruction has been fetched; fetch frozen.
REQ-016 fetch_count  output  32  number of valid instructions written into IF/ID.
REQ-017 stall_count  output  32  number of cycles in which stall held the stage.

Function
REQ-018 imem_addr SHALL equal the PC register combinationally, no added latency.
REQ-019 Fetch-to-IF/ID latency SHALL be one cycle: the instruction at PC appears on if_id_instr after the next rising edge.
REQ-020 Priority per cycle SHALL be: redirect_valid > stall > halted > normal fetch.
REQ-021 Normal (no redirect, no stall, not halted): PC <= PC+4 (wraps 32'hFFFFFFFC -> 0); IF/ID <= {PC, imem_instr, valid=1}; fetch_count += 1.
REQ-022 Redirect: PC <= {redirect_pc[31:2],2'b00}; IF/ID <= {pc 0, NOP_INSTR, valid=0}; halted <= 0; applies even when stall=1 or halted=1.
REQ-023 Stall without redirect: PC, IF/ID, halted hold; stall_count += 1; fetch_count unchanged.
REQ-024 Halt detect: on a normal fetch where imem_instr == HALT_INSTR, the halt instruction SHALL be latched (valid=1, counted) and halted <= 1 on the same edge.
REQ-025 While halted and no redirect/stall: PC holds at halt address + 4; IF/ID <= {pc 0, NOP_INSTR, valid=0}; fetch_count unchanged.
REQ-026 A redirect in the same cycle as a halt-encoding fetch SHALL win: halt not latched, halted stays 0.
REQ-027 States SHALL be RUN (halted=0) and HALT (halted=1): RUN->HALT per REQ-024; HALT->RUN only on redirect or reset.
REQ-028 Both counters SHALL wrap modulo 2^32 with no saturation flag.
REQ-029 if_id_pc4 SHALL be derived combinationally from if_id_pc.

Reset
REQ-030 On rst=1, asynchronously: PC=RESET_PC, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0, halted=0, fetch_count=0, stall_count=0.
REQ-031 Reset asserted mid-operation (including during stall, redirect or HALT) SHALL override all inputs; first fetch after deassertion is from RESET_PC.

Verification
REQ-032 Reset release, imem holds 00400093,00600113,002081B3 at words 0-2, no stall -> imem_addr 0,4,8 on successive cycles; if_id_instr 00400093 then 00600113 with valid=1; fetch_count=2 after two edges.
REQ-033 Stall high 3 cycles with PC=8 -> imem_addr stays 8, IF/ID unchanged, stall_count=3, fetch_count unchanged.
REQ-034 redirect_valid=1, redirect_pc=32'h00000013 while stall=1 -> PC=32'h00000010, if_id_instr=00000013, if_id_valid=0, stall_count not incremented.
REQ-035 Program reaches 00000073 at word 8 -> if_id_instr=00000073 valid=1, halted=1; following cycles imem_addr=32'h24, if_id_valid=0; then redirect to 0x0 -> halted=0, fetch resumes at 0.
REQ-036 PC forced via redirect to 32'hFFFFFFFC, no stall -> next imem_addr=0, if_id_pc=32'hFFFFFFFC, if_id_pc4=0.
REQ-037 rst pulsed asynchronously between edges during HALT -> all outputs at REQ-030 values immediately, before next clock edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, halt FSM and
// fetch/stall event counters. Redirect beats stall, stall beats halt.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h00000000,
  parameter logic [31:0] HALT_INSTR = 32'h00000073,
  parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] ifpc_nx, ifinstr_nx;
  logic        ifvalid_nx;
  logic [31:0] fcnt_nx, scnt_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      if_id_pc    <= 32'h0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
      fetch_count <= 32'h0;
      stall_count <= 32'h0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      if_id_pc    <= ifpc_nx;
      if_id_instr <= ifinstr_nx;
      if_id_valid <= ifvalid_nx;
      fetch_count <= fcnt_nx;
      stall_count <= scnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    ifpc_nx    = if_id_pc;
    ifinstr_nx = if_id_instr;
    ifvalid_nx = if_id_valid;
    fcnt_nx    = fetch_count;
    scnt_nx    = stall_count;
    if (redirect_valid) begin
      // Flush: the word fetched this cycle is on the wrong path.
      state_nx   = RUN;
      pc_nx      = {redirect_pc[31:2], 2'b00};
      ifpc_nx    = 32'h0;
      ifinstr_nx = NOP_INSTR;
      ifvalid_nx = 1'b0;
    end else if (stall) begin
      scnt_nx = stall_count + 32'd1;
    end else begin
      case (state)
        RUN: begin
          pc_nx      = pc + 32'd4;
          ifpc_nx    = pc;
          ifinstr_nx = imem_instr;
          ifvalid_nx = 1'b1;
          fcnt_nx    = fetch_count + 32'd1;
          if (imem_instr == HALT_INSTR) state_nx = HALT;
        end
        HALT: begin
          ifpc_nx    = 32'h0;
          ifinstr_nx = NOP_INSTR;
          ifvalid_nx = 1'b0;
        end
        default: state_nx = RUN;
      endcase
    end
  end

  assign imem_addr = pc;
  assign if_id_pc4 = if_id_pc + 32'd4;
  assign halted    = (state == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random stall/redirect/halt
// traffic, all compared against a rule-level reference model.
module tb_fetch_stage;
  localparam logic [31:0] HALT = 32'h00000073;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] imem_addr, imem_instr;
  logic [31:0] if_id_pc, if_id_pc4, if_id_instr;
  logic        if_id_valid, halted;
  logic [31:0] fetch_count, stall_count;

  logic [31:0] mem [256];
  assign imem_instr = mem[imem_addr[9:2]];

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4), .if_id_instr(if_id_instr),
    .if_id_valid(if_id_valid), .halted(halted), .fetch_count(fetch_count),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] m_pc, m_ipc, m_iin, m_fc, m_sc;
  logic        m_iv, m_h;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("imem_addr", imem_addr, m_pc);
    chk("if_id_pc", if_id_pc, m_ipc);
    chk("if_id_pc4", if_id_pc4, m_ipc + 32'd4);
    chk("if_id_instr", if_id_instr, m_iin);
    chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_iv});
    chk("halted", {31'b0, halted}, {31'b0, m_h});
    chk("fetch_count", fetch_count, m_fc);
    chk("stall_count", stall_count, m_sc);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ipc = 32'h0; m_iin = NOP; m_iv = 1'b0;
    m_h = 1'b0; m_fc = 32'h0; m_sc = 32'h0;
  endtask

  // one clock: model advances by the priority rules, then outputs are compared
  task automatic cycle();
    logic [31:0] w;
    if (redirect_valid) begin
      m_pc = redirect_pc & 32'hFFFFFFFC;
      m_ipc = 0; m_iin = NOP; m_iv = 0; m_h = 0;
    end else if (stall) begin
      m_sc = m_sc + 1;
    end else if (m_h) begin
      m_ipc = 0; m_iin = NOP; m_iv = 0;
    end else begin
      w = mem[m_pc[9:2]];
      m_ipc = m_pc; m_iin = w; m_iv = 1; m_fc = m_fc + 1;
      m_pc = m_pc + 4;
      if (w == HALT) m_h = 1;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input logic s, input logic r, input logic [31:0] rp);
    stall = s; redirect_valid = r; redirect_pc = rp;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = NOP;
    mem[0] = 32'h00400093; mem[1] = 32'h00600113; mem[2] = 32'h002081B3;
    mem[8] = HALT;
    model_reset();
    #12;
    check_all();                       // reset values
    @(negedge clk); rst = 1'b0; #1;
    chk("first_addr", imem_addr, 32'h0);

    // straight-line fetch from reset
    cycle(); chk("i0", if_id_instr, 32'h00400093); chk("addr4", imem_addr, 32'h4);
    cycle(); chk("i1", if_id_instr, 32'h00600113); chk("fc2", fetch_count, 32'd2);

    // three stalled cycles at PC=8
    drive(1, 0, 0);
    repeat (3) cycle();
    chk("stall_addr", imem_addr, 32'h8); chk("sc3", stall_count, 32'd3);

    // redirect wins over stall
    drive(1, 1, 32'h00000013);
    cycle();
    chk("redir_pc", imem_addr, 32'h10); chk("sc_hold", stall_count, 32'd3);

    // run into the halt at word 8
    drive(0, 0, 0);
    repeat (5) cycle();
    chk("halt_instr", if_id_instr, HALT); chk("halted", {31'b0, halted}, 32'd1);
    repeat (2) cycle();
    chk("halt_addr", imem_addr, 32'h24);

    // stall while halted still counts
    drive(1, 0, 0); cycle();
    drive(0, 1, 32'h0); cycle();
    chk("resume", {31'b0, halted}, 32'd0);
    drive(0, 0, 0); cycle();
    chk("resume_pc", if_id_pc, 32'h0);

    // PC wrap at the top of the address space
    drive(0, 1, 32'hFFFFFFFC); cycle();
    drive(0, 0, 0); cycle();
    chk("wrap_addr", imem_addr, 32'h0); chk("wrap_pc4", if_id_pc4, 32'h0);

    // redirect in the same cycle as a halt-encoding fetch
    drive(0, 1, 32'h20); cycle();
    drive(0, 1, 32'h0); cycle();
    chk("redir_vs_halt", {31'b0, halted}, 32'd0);

    // async reset in HALT between edges
    drive(0, 1, 32'h20); cycle();
    drive(0, 0, 0); repeat (2) cycle();
    @(negedge clk); #2;
    rst = 1'b1; #1;
    model_reset();
    check_all();
    @(negedge clk); rst = 1'b0;

    // random traffic
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
